// File: rtl/sigma_delta_pkg.sv
// Shared definitions for the 1-bit sigma-delta audio path (ADC and DAC sides).
package sigma_delta_pkg;

  localparam int unsigned MSBI_DEF    = 7;
  localparam int unsigned DECLOG2_DEF = 5;

  // Priming progress of the two-stage comb history after reset
  typedef enum logic [1:0] {
    PRIME_EMPTY = 2'd0,
    PRIME_HALF  = 2'd1,
    PRIME_FULL  = 2'd2
  } prime_t;

  // Integrator/comb register width for a 2nd-order CIC with R = 2**declog2
  function automatic int unsigned cic_width(input int unsigned declog2);
    return 2 * declog2 + 1;
  endfunction

  // Mid-scale code of the excess-2**msbi PCM format
  function automatic int unsigned mid_scale(input int unsigned msbi);
    return 32'd1 << msbi;
  endfunction

  localparam int unsigned MID_SCALE = mid_scale(MSBI_DEF);

endpackage

// File: rtl/cic2_decim.sv
// 2nd-order CIC decimator: integrators, frame counter, two-stage comb,
// full-scale saturation and post-reset priming. One PCM word per R samples.
module cic2_decim
  import sigma_delta_pkg::*;
#(
  parameter int unsigned DECLOG2 = DECLOG2_DEF,
  parameter int unsigned MSBI    = MSBI_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ce,
  input  logic            i_x,
  output logic [MSBI:0]   o_adc_out,
  output logic            o_adc_valid
);

  localparam int unsigned W   = cic_width(DECLOG2);
  localparam int unsigned DW  = 2 * DECLOG2;
  localparam int unsigned LSB = DW - MSBI - 1;
  localparam int unsigned R   = 1 << DECLOG2;
  localparam logic [W-1:0]  FULL_SCALE = W'(R * R);
  localparam logic [DW-1:0] SAT_MAX    = DW'(R * R - 1);

  if (2 * DECLOG2 < MSBI + 1) begin : g_param_check
    $error("cic2_decim: 2*DECLOG2 must be >= MSBI+1");
  end

  logic [DECLOG2-1:0] r_cnt;
  logic [W-1:0]       r_i1, r_i2;
  logic [W-1:0]       w_i1_next, w_i2_next;
  logic               w_tick;
  logic [W-1:0]       r_d, r_d_prev, r_c1, r_c1_prev;
  logic               r_stg1, r_stg2;
  logic [W-1:0]       w_c2;
  logic [DW-1:0]      w_sat;
  prime_t             r_prime, w_prime_next;
  logic               w_emit;

  assign w_i1_next = r_i1 + W'(i_x);
  assign w_i2_next = r_i2 + w_i1_next;
  assign w_tick    = i_ce && (r_cnt == '1);
  assign w_c2      = r_c1 - r_c1_prev;
  assign w_sat     = (w_c2 >= FULL_SCALE) ? SAT_MAX : w_c2[DW-1:0];

  // Integrators and frame counter advance only on sample enable; wrap is intended
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_cnt <= '0;
    end else if (i_ce) begin
      r_i1  <= w_i1_next;
      r_i2  <= w_i2_next;
      r_cnt <= r_cnt + DECLOG2'(1);
    end
  end

  // Snapshot, comb stages and output run every CLK so latency is fixed at 2
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d         <= '0;
      r_d_prev    <= '0;
      r_c1        <= '0;
      r_c1_prev   <= '0;
      r_stg1      <= 1'b0;
      r_stg2      <= 1'b0;
      o_adc_out   <= '0;
      o_adc_valid <= 1'b0;
    end else begin
      r_stg1      <= w_tick;
      r_stg2      <= r_stg1;
      o_adc_valid <= w_emit;
      if (w_tick) begin
        r_d <= w_i2_next;
      end
      if (r_stg1) begin
        r_c1     <= r_d - r_d_prev;
        r_d_prev <= r_d;
      end
      if (r_stg2) begin
        r_c1_prev <= r_c1;
      end
      if (w_emit) begin
        o_adc_out <= w_sat[DW-1:LSB];
      end
    end
  end

  // Priming state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prime <= PRIME_EMPTY;
    end else begin
      r_prime <= w_prime_next;
    end
  end

  // Priming next state: first two comb results only fill history
  always_comb begin
    w_prime_next = r_prime;
    w_emit       = 1'b0;
    case (r_prime)
      PRIME_EMPTY: if (r_stg2) w_prime_next = PRIME_HALF;
      PRIME_HALF:  if (r_stg2) w_prime_next = PRIME_FULL;
      PRIME_FULL:  w_emit = r_stg2;
      default:     w_prime_next = PRIME_EMPTY;
    endcase
  end

endmodule

// File: rtl/sigma_delta_adc.sv
// Receive side of the 1-bit sigma-delta path: synchronizes the comparator
// bitstream, drives the RC loop feedback bit and decimates to PCM.
module sigma_delta_adc
  import sigma_delta_pkg::*;
#(
  parameter int unsigned MSBI    = MSBI_DEF,
  parameter int unsigned DECLOG2 = DECLOG2_DEF
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          CE,
  input  logic          SDin,
  output logic          FBout,
  output logic [MSBI:0] ADCout,
  output logic          ADCvalid
);

  logic [1:0] r_sync;
  logic       w_s;

  assign w_s = r_sync[1];

  // Two-flop synchronizer for the asynchronous comparator output, free-running
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], SDin};
    end
  end

  // Feedback bit follows the sampled bit and holds between samples
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FBout <= 1'b0;
    end else if (CE) begin
      FBout <= w_s;
    end
  end

  cic2_decim #(
    .DECLOG2 (DECLOG2),
    .MSBI    (MSBI)
  ) u_cic2_decim (
    .i_clk       (CLK),
    .i_rst_n     (RESET_N),
    .i_ce        (CE),
    .i_x         (w_s),
    .o_adc_out   (ADCout),
    .o_adc_valid (ADCvalid)
  );

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Scoreboard bench for sigma_delta_adc: stimulus queues expected PCM words
// and their arrival cycles; a negedge monitor pops and compares on ADCvalid.
module tb_sigma_delta_adc;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       CE;
  logic       SDin;
  logic       FBout;
  logic [7:0] ADCout;
  logic       ADCvalid;

  sigma_delta_adc #(.MSBI(7), .DECLOG2(5)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .CE       (CE),
    .SDin     (SDin),
    .FBout    (FBout),
    .ADCout   (ADCout),
    .ADCvalid (ADCvalid)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare each ADCvalid pulse against the scoreboard head
  always @(negedge CLK) begin
    exp_t e;
    if (prev_valid) check("valid_width", 32'(ADCvalid), 32'd0);
    if (ADCvalid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: ADCvalid at cycle %0d, required none", cyc);
      end else begin
        e = sb_q.pop_front();
        check("adc_out", 32'(ADCout), 32'(e.val));
        check("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_valid = ADCvalid;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    CE      = 1'b0;
    SDin    = 1'b0;
    step();
    step();
  endtask

  // Runs one pattern from a fresh reset; first result is the 3rd tick
  task automatic run(input logic [3:0] pat, input int div, input logic [7:0] exp_val,
                     input int n_exp, input string tag);
    int c0;
    int ncyc;
    exp_t e;
    do_reset();
    RESET_N = 1'b1;
    c0 = cyc;
    for (int j = 0; j < n_exp; j++) begin
      e.val = exp_val;
      e.cyc = c0 + 96 * div + 2 + j * 32 * div;
      sb_q.push_back(e);
    end
    ncyc = 96 * div + 2 + (n_exp - 1) * 32 * div + 4;
    for (int i = 1; i <= ncyc; i++) begin
      CE   = ((i % div) == 0);
      SDin = pat[i % 4];
      step();
    end
    check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int   c0;
    exp_t e;

    // Reset state
    do_reset();
    check("rst_adcout", 32'(ADCout), 32'd0);
    check("rst_valid", 32'(ADCvalid), 32'd0);
    check("rst_fbout", 32'(FBout), 32'd0);

    // FBout follows SDin three CLK later, holds while CE=0
    RESET_N = 1'b1;
    CE      = 1'b1;
    SDin    = 1'b0;
    repeat (4) step();
    SDin = 1'b1;
    step();
    check("fb_lat1", 32'(FBout), 32'd0);
    step();
    check("fb_lat2", 32'(FBout), 32'd0);
    step();
    check("fb_lat3", 32'(FBout), 32'd1);
    CE   = 1'b0;
    SDin = 1'b0;
    repeat (5) step();
    check("fb_hold_ce0", 32'(FBout), 32'd1);
    CE = 1'b1;
    step();
    check("fb_resample", 32'(FBout), 32'd0);

    // Steady-state decode of periodic bitstreams
    run(4'b0000, 1, 8'h00, 3, "zeros");
    run(4'b1111, 1, 8'hFF, 3, "ones");
    run(4'b1010, 1, 8'h80, 3, "toggle");
    run(4'b0001, 1, 8'h40, 3, "one_in_four");
    run(4'b0111, 1, 8'hC0, 3, "three_in_four");
    run(4'b1111, 3, 8'hFF, 2, "ce_div3");

    // Reset with a result in flight: nothing emitted, priming restarts
    do_reset();
    RESET_N = 1'b1;
    c0 = cyc;
    e.val = 8'hFF;
    e.cyc = c0 + 98;
    sb_q.push_back(e);
    for (int i = 1; i <= 129; i++) begin
      CE   = 1'b1;
      SDin = 1'b1;
      step();
    end
    check("pre_rst_adcout", 32'(ADCout), 32'hFF);
    RESET_N = 1'b0;
    #1;
    check("midrst_adcout", 32'(ADCout), 32'd0);
    check("midrst_valid", 32'(ADCvalid), 32'd0);
    check("midrst_fbout", 32'(FBout), 32'd0);
    step();
    RESET_N = 1'b1;
    c0 = cyc;
    for (int j = 0; j < 2; j++) begin
      e.val = 8'hFF;
      e.cyc = c0 + 98 + j * 32;
      sb_q.push_back(e);
    end
    for (int i = 1; i <= 98 + 32 + 4; i++) begin
      CE   = 1'b1;
      SDin = 1'b1;
      step();
    end
    check("midrst_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
